// File: rtl/hdng_pkg.sv
// Shared types and constants for the heading-error source.
package hdng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    RUN  = 2'd2
  } hdng_state_t;

  localparam int unsigned HDNG_W = 12;
  localparam int unsigned ERR_W  = 10;
  localparam int unsigned YAW_W  = 16;

  localparam logic signed [ERR_W-1:0] ERR_MAX = 10'sd511;
  localparam logic signed [ERR_W-1:0] ERR_MIN = -10'sd512;

endpackage

// File: rtl/err_sat10.sv
// Combinational 12-bit to 10-bit signed saturator for the heading error.
module err_sat10
  import hdng_pkg::*;
(
  input  logic signed [HDNG_W-1:0] diff,
  output logic signed [ERR_W-1:0]  sat_c
);

  // Clamp to the representable error range, pass through otherwise.
  always_comb begin
    sat_c = diff[ERR_W-1:0];
    if (diff > HDNG_W'(ERR_MAX)) begin
      sat_c = ERR_MAX;
    end else if (diff < HDNG_W'(ERR_MIN)) begin
      sat_c = ERR_MIN;
    end
  end

endmodule

// File: rtl/hdng_err_src.sv
// Gyro offset calibration, yaw-rate integration and saturated heading error.
module hdng_err_src
  import hdng_pkg::*;
#(
  parameter int unsigned CAL_SHIFT  = 11,
  parameter int unsigned HDNG_SHIFT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     strt_cal,
  input  logic                     yaw_vld,
  input  logic signed [YAW_W-1:0]  yaw_rt,
  input  logic signed [HDNG_W-1:0] dsrd_hdng,
  output logic                     cal_done,
  output logic signed [HDNG_W-1:0] heading,
  output logic signed [ERR_W-1:0]  err_sat,
  output logic                     hdng_vld
);

  localparam int unsigned CAL_W  = YAW_W + CAL_SHIFT;
  localparam int unsigned ACC_W  = HDNG_W + HDNG_SHIFT;
  localparam int unsigned RATE_W = YAW_W + 1;

  hdng_state_t state_q, state_d;

  logic signed [CAL_W-1:0]   cal_acc_q;
  logic        [CAL_SHIFT-1:0] cal_cnt_q;
  logic signed [YAW_W-1:0]   offset_q;
  logic signed [ACC_W-1:0]   hdng_acc_q;
  logic                      stg2_q;
  logic                      cal_done_q;
  logic signed [ERR_W-1:0]   err_q;
  logic                      hdng_vld_q;

  logic                      cal_smp_c;
  logic                      cal_last_c;
  logic                      run_smp_c;
  logic signed [CAL_W-1:0]   cal_sum_c;
  logic signed [RATE_W-1:0]  rate_c;
  logic signed [HDNG_W-1:0]  diff_c;
  logic signed [ERR_W-1:0]   sat_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and sample qualifiers; strt_cal overrides any same-cycle sample.
  always_comb begin
    state_d    = state_q;
    cal_smp_c  = 1'b0;
    cal_last_c = 1'b0;
    run_smp_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (strt_cal) state_d = CAL;
      end
      CAL: begin
        if (strt_cal) begin
          state_d = CAL;
        end else if (yaw_vld) begin
          cal_smp_c = 1'b1;
          if (cal_cnt_q == '1) begin
            cal_last_c = 1'b1;
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        if (strt_cal) begin
          state_d = CAL;
        end else if (yaw_vld) begin
          run_smp_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath arithmetic: calibration sum, offset-corrected rate, heading difference.
  always_comb begin
    cal_sum_c = cal_acc_q + CAL_W'(yaw_rt);
    rate_c    = RATE_W'(yaw_rt) - RATE_W'(offset_q);
    diff_c    = heading - dsrd_hdng;
  end

  // Calibration accumulator, sample counter and offset capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_acc_q  <= '0;
      cal_cnt_q  <= '0;
      offset_q   <= '0;
      cal_done_q <= 1'b0;
    end else begin
      cal_done_q <= cal_last_c;
      if (strt_cal) begin
        cal_acc_q <= '0;
        cal_cnt_q <= '0;
      end else if (cal_last_c) begin
        offset_q  <= YAW_W'(cal_sum_c >>> CAL_SHIFT);
        cal_acc_q <= '0;
        cal_cnt_q <= '0;
      end else if (cal_smp_c) begin
        cal_acc_q <= cal_sum_c;
        cal_cnt_q <= cal_cnt_q + CAL_SHIFT'(1);
      end
    end
  end

  // Stage 1: heading integrator; modulo wrap is the intended angle behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdng_acc_q <= '0;
      stg2_q     <= 1'b0;
    end else begin
      stg2_q <= run_smp_c;
      if (run_smp_c) begin
        hdng_acc_q <= hdng_acc_q + ACC_W'(rate_c);
      end
    end
  end

  // Stage 2 saturator on the wrapped (shortest-path) difference.
  err_sat10 u_sat (
    .diff  (diff_c),
    .sat_c (sat_c)
  );

  // Stage 2 output registers; an op in flight completes even across strt_cal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= '0;
      hdng_vld_q <= 1'b0;
    end else begin
      hdng_vld_q <= stg2_q;
      if (stg2_q) begin
        err_q <= sat_c;
      end
    end
  end

  assign heading  = hdng_acc_q[ACC_W-1 -: HDNG_W];
  assign err_sat  = err_q;
  assign hdng_vld = hdng_vld_q;
  assign cal_done = cal_done_q;

endmodule
